sprite_anim_sequencer: RTL and testbench

Owns the position/direction/size state of N_SPR bouncing rectangles and sequences one shared update engine across them once per frame, at the vertical-blank animate event from the 640x480 timing generator. Arbitrates the single register-file write port between the frame sequencer and a host configuration port. Exports per-sprite bounding boxes to the pixel-compare logic in the top level.

---
 rtl/sprite_anim_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_sprite_anim_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_anim_sequencer.sv
// Per-frame bouncing-sprite updater: one shared FETCH/CALC/WRITE engine walks all sprites
// on each vblank edge, sharing the sprite register file's write port with a host config port.

module sprite_bbox #(
    parameter int COORD_W = 12
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [COORD_W-1:0] h,
    output logic [COORD_W-1:0] x1,
    output logic [COORD_W-1:0] x2,
    output logic [COORD_W-1:0] y1,
    output logic [COORD_W-1:0] y2
);
    // Wraps modulo 2^COORD_W when h exceeds the centre; software keeps h sane.
    assign x1 = x - h;
    assign x2 = x + h;
    assign y1 = y - h;
    assign y2 = y + h;
endmodule

module sprite_anim_sequencer #(
    parameter int N_SPR    = 3,
    parameter int COORD_W  = 12,
    parameter int D_WIDTH  = 640,
    parameter int D_HEIGHT = 480,
    parameter int H_SIZE   = 80,
    parameter int STEP     = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_animate,
    input  logic                     i_cfg_valid,
    output logic                     o_cfg_ready,
    input  logic [2:0]               i_cfg_idx,
    input  logic [1:0]               i_cfg_field,
    input  logic [COORD_W-1:0]       i_cfg_data,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_overrun,
    output logic [N_SPR*COORD_W-1:0] o_x1,
    output logic [N_SPR*COORD_W-1:0] o_x2,
    output logic [N_SPR*COORD_W-1:0] o_y1,
    output logic [N_SPR*COORD_W-1:0] o_y2
);
    localparam int IW = (N_SPR > 1) ? $clog2(N_SPR) : 1;
    localparam logic [COORD_W:0] X_LIM = (COORD_W+1)'(D_WIDTH - 1);
    localparam logic [COORD_W:0] Y_LIM = (COORD_W+1)'(D_HEIGHT - 1);

    typedef enum logic [2:0] {IDLE, FETCH, CALC, WRITE, DONE} state_t;

    state_t state, state_nx;

    logic [N_SPR-1:0][COORD_W-1:0] x, y, h;
    logic [N_SPR-1:0]              x_dir, y_dir, en, dirty;

    logic [IW-1:0]      idx;
    logic [COORD_W-1:0] wx, wy, wh;
    logic               wx_dir, wy_dir;
    logic               prev_animate;

    logic          rise, last, cfg_fire, cfg_hit;
    logic [IW-1:0] cidx;

    assign rise     = i_animate & ~prev_animate;
    assign last     = (idx == IW'(N_SPR - 1));
    assign cfg_fire = i_cfg_valid & o_cfg_ready;
    assign cfg_hit  = (int'(i_cfg_idx) < N_SPR);
    assign cidx     = i_cfg_idx[IW-1:0];

    // Returns {dir, pos}. Compares run one bit wider so x+STEP and h+STEP cannot wrap;
    // the far limit saturates at 0 instead of underflowing for an oversized h.
    function automatic logic [COORD_W:0] axis_step(
        input logic [COORD_W-1:0] p,
        input logic [COORD_W-1:0] hs,
        input logic               d,
        input logic [COORD_W:0]   lim
    );
        logic [COORD_W:0] pe, he, hi, st;
        pe = {1'b0, p};
        he = {1'b0, hs};
        st = (COORD_W+1)'(STEP);
        hi = (he > lim) ? '0 : lim - he;
        if (d && (pe + st >= hi))
            return {1'b0, hi[COORD_W-1:0]};
        else if (!d && (pe <= he + st))
            return {1'b1, hs};
        else if (d)
            return {1'b1, p + COORD_W'(STEP)};
        else
            return {1'b0, p - COORD_W'(STEP)};
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        o_busy      = 1'b1;
        o_done      = 1'b0;
        o_cfg_ready = 1'b1;
        case (state)
            IDLE: begin
                o_busy = 1'b0;
                if (rise) state_nx = FETCH;
            end
            FETCH: begin
                if (!en[idx]) state_nx = last ? DONE : FETCH;
                else          state_nx = CALC;
            end
            CALC:  state_nx = WRITE;
            WRITE: begin
                o_cfg_ready = 1'b0;
                state_nx    = last ? DONE : FETCH;
            end
            DONE: begin
                o_done   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign o_overrun = rise && (state != IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < N_SPR; k++) begin
                x[k] <= COORD_W'((k + 1) * D_WIDTH / (N_SPR + 1));
                y[k] <= COORD_W'((k + 1) * D_HEIGHT / (N_SPR + 1));
                h[k] <= COORD_W'(H_SIZE);
            end
            x_dir        <= '1;
            y_dir        <= '1;
            en           <= '1;
            dirty        <= '0;
            idx          <= '0;
            wx           <= '0;
            wy           <= '0;
            wh           <= '0;
            wx_dir       <= 1'b0;
            wy_dir       <= 1'b0;
            prev_animate <= 1'b0;
        end else begin
            prev_animate <= i_animate;

            // Host port never fires in WRITE, so it cannot collide with the writeback below.
            if (cfg_fire && cfg_hit) begin
                case (i_cfg_field)
                    2'd0: x[cidx] <= i_cfg_data;
                    2'd1: y[cidx] <= i_cfg_data;
                    2'd2: h[cidx] <= i_cfg_data;
                    default: {en[cidx], y_dir[cidx], x_dir[cidx]} <= i_cfg_data[2:0];
                endcase
                if ((state == FETCH || state == CALC) && cidx == idx)
                    dirty[cidx] <= 1'b1;
            end

            case (state)
                IDLE: if (rise) idx <= '0;
                FETCH: begin
                    wx     <= x[idx];
                    wy     <= y[idx];
                    wh     <= h[idx];
                    wx_dir <= x_dir[idx];
                    wy_dir <= y_dir[idx];
                    if (!en[idx] && !last) idx <= idx + 1'b1;
                end
                CALC: begin
                    {wx_dir, wx} <= axis_step(wx, wh, wx_dir, X_LIM);
                    {wy_dir, wy} <= axis_step(wy, wh, wy_dir, Y_LIM);
                end
                WRITE: begin
                    // A host write that landed mid-update owns this sprite for the frame.
                    if (!dirty[idx]) begin
                        x[idx]     <= wx;
                        y[idx]     <= wy;
                        x_dir[idx] <= wx_dir;
                        y_dir[idx] <= wy_dir;
                    end
                    if (!last) idx <= idx + 1'b1;
                end
                DONE: dirty <= '0;
                default: ;
            endcase
        end
    end

    for (genvar k = 0; k < N_SPR; k++) begin : g_box
        sprite_bbox #(.COORD_W(COORD_W)) u_box (
            .x  (x[k]),
            .y  (y[k]),
            .h  (h[k]),
            .x1 (o_x1[k*COORD_W +: COORD_W]),
            .x2 (o_x2[k*COORD_W +: COORD_W]),
            .y1 (o_y1[k*COORD_W +: COORD_W]),
            .y2 (o_y2[k*COORD_W +: COORD_W])
        );
    end

endmodule

// File: tb/tb_sprite_anim_sequencer.sv
// Bench for sprite_anim_sequencer: frame-level reference model of sprite motion and
// sequencer timing, directed scenarios plus randomized sprite configurations.
module tb_sprite_anim_sequencer;
    localparam int N  = 3;
    localparam int CW = 12;
    localparam int W  = 640;
    localparam int H  = 480;
    localparam int HS = 80;
    localparam int ST = 1;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_animate = 1'b0;
    logic          i_cfg_valid = 1'b0;
    logic          o_cfg_ready;
    logic [2:0]    i_cfg_idx = '0;
    logic [1:0]    i_cfg_field = '0;
    logic [CW-1:0] i_cfg_data = '0;
    logic          o_busy, o_done, o_overrun;
    logic [N*CW-1:0] o_x1, o_x2, o_y1, o_y2;

    sprite_anim_sequencer #(
        .N_SPR(N), .COORD_W(CW), .D_WIDTH(W), .D_HEIGHT(H), .H_SIZE(HS), .STEP(ST)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_animate(i_animate),
        .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready),
        .i_cfg_idx(i_cfg_idx), .i_cfg_field(i_cfg_field), .i_cfg_data(i_cfg_data),
        .o_busy(o_busy), .o_done(o_done), .o_overrun(o_overrun),
        .o_x1(o_x1), .o_x2(o_x2), .o_y1(o_y1), .o_y2(o_y2)
    );

    always #5 i_clk = ~i_clk;

    int vec = 0;
    int bad = 0;

    int mx[N], my[N], mh[N];
    bit mxd[N], myd[N], men[N];

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            mx[k] = (k + 1) * W / (N + 1);
            my[k] = (k + 1) * H / (N + 1);
            mh[k] = HS;
            mxd[k] = 1; myd[k] = 1; men[k] = 1;
        end
    endfunction

    // One frame of motion: each enabled sprite moves STEP per axis, bouncing at the walls.
    function automatic void model_step();
        int p; bit d;
        for (int k = 0; k < N; k++) begin
            if (!men[k]) continue;
            p = mx[k]; d = mxd[k];
            if (d && p + ST >= W - 1 - mh[k]) begin p = W - 1 - mh[k]; d = 0; end
            else if (!d && p <= mh[k] + ST) begin p = mh[k]; d = 1; end
            else p = d ? p + ST : p - ST;
            mx[k] = p; mxd[k] = d;
            p = my[k]; d = myd[k];
            if (d && p + ST >= H - 1 - mh[k]) begin p = H - 1 - mh[k]; d = 0; end
            else if (!d && p <= mh[k] + ST) begin p = mh[k]; d = 1; end
            else p = d ? p + ST : p - ST;
            my[k] = p; myd[k] = d;
        end
    endfunction

    function automatic int exp_done();
        int c = 0;
        for (int k = 0; k < N; k++) c += men[k] ? 3 : 1;
        return c + 1;
    endfunction

    function automatic logic [4*N*CW-1:0] exp_boxes();
        logic [N*CW-1:0] a, b, c, d;
        for (int k = 0; k < N; k++) begin
            a[k*CW +: CW] = CW'(mx[k] - mh[k]);
            b[k*CW +: CW] = CW'(mx[k] + mh[k]);
            c[k*CW +: CW] = CW'(my[k] - mh[k]);
            d[k*CW +: CW] = CW'(my[k] + mh[k]);
        end
        return {a, b, c, d};
    endfunction

    function automatic void model_cfg(input int idx, input int f, input int data);
        if (idx >= N) return;
        case (f)
            0: mx[idx] = data;
            1: my[idx] = data;
            2: mh[idx] = data;
            default: begin men[idx] = data[2]; myd[idx] = data[1]; mxd[idx] = data[0]; end
        endcase
    endfunction

    // Called in the low clock phase; returns in the low phase.
    task automatic cfg_write(input int idx, input int f, input int data);
        i_cfg_valid = 1'b1;
        i_cfg_idx   = 3'(idx);
        i_cfg_field = 2'(f);
        i_cfg_data  = CW'(data);
        @(posedge i_clk); #1;
        i_cfg_valid = 1'b0;
        model_cfg(idx, f, data);
        @(negedge i_clk);
    endtask

    // Cycle 0 is the cycle whose closing edge samples the animate rise. Inputs for cycle c
    // are driven at its negedge, outputs sampled 1 ns later. Fixed 24-cycle window.
    task automatic frame(input int hold, input int edge2, input int rst_at, input int cfg_mode,
                         output int done_c, output int ndone, output int nover, output int rdy_mask);
        done_c = -1; ndone = 0; nover = 0; rdy_mask = 0;
        i_animate = 1'b1;
        for (int c = 1; c < 24; c++) begin
            @(negedge i_clk);
            i_animate = (c < hold) || (c == edge2);
            i_rst     = (c == rst_at);
            if (cfg_mode != 0) begin
                i_cfg_valid = 1'b1;
                i_cfg_field = 2'd0;
                i_cfg_idx   = (c == 5) ? 3'd1 : 3'd7;
                i_cfg_data  = (c == 5) ? CW'(300) : CW'(0);
            end
            #1;
            if (o_done) begin ndone++; if (done_c < 0) done_c = c; end
            if (o_overrun) nover++;
            if (!o_cfg_ready) rdy_mask |= (1 << c);
        end
        i_animate = 1'b0; i_rst = 1'b0; i_cfg_valid = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        model_reset();
        vec++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", o_busy); end
        vec++; if (o_done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", o_done); end
        vec++; if (o_overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got %b want 0", o_overrun); end
        vec++; if (o_cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", o_cfg_ready); end
        vec++; if ({o_x1, o_x2, o_y1, o_y2} !== exp_boxes()) begin
            bad++; $display("FAIL reset_boxes got %h want %h", {o_x1, o_x2, o_y1, o_y2}, exp_boxes());
        end
    endtask

    task automatic test_basic_frame();
        int dc, nd, no, rm;
        frame(1, -1, -1, 0, dc, nd, no, rm);
        model_step();
        vec++; if (dc !== 10) begin bad++; $display("FAIL basic_done_cycle got %0d want 10", dc); end
        vec++; if (nd !== 1) begin bad++; $display("FAIL basic_done_count got %0d want 1", nd); end
        vec++; if (no !== 0) begin bad++; $display("FAIL basic_overrun got %0d want 0", no); end
        vec++; if (o_x1[CW-1:0] !== 12'd81 || o_x2[CW-1:0] !== 12'd241) begin
            bad++; $display("FAIL basic_spr0_x got %0d/%0d want 81/241", o_x1[CW-1:0], o_x2[CW-1:0]);
        end
        vec++; if ({o_x1, o_x2, o_y1, o_y2} !== exp_boxes()) begin
            bad++; $display("FAIL basic_boxes got %h want %h", {o_x1, o_x2, o_y1, o_y2}, exp_boxes());
        end
    endtask

    task automatic test_host_write();
        i_cfg_valid = 1'b1; i_cfg_idx = 3'd2; i_cfg_field = 2'd0; i_cfg_data = CW'(200);
        @(posedge i_clk); #1;
        i_cfg_valid = 1'b0;
        model_cfg(2, 0, 200);
        vec++; if (o_x1[2*CW +: CW] !== CW'(200 - HS)) begin
            bad++; $display("FAIL host_write_next_cycle got %0d want %0d", o_x1[2*CW +: CW], 200 - HS);
        end
        @(negedge i_clk);
        cfg_write(5, 0, 7);
        vec++; if ({o_x1, o_x2, o_y1, o_y2} !== exp_boxes()) begin
            bad++; $display("FAIL host_write_bad_idx got %h want %h", {o_x1, o_x2, o_y1, o_y2}, exp_boxes());
        end
    endtask

    task automatic test_x_bounce();
        int dc, nd, no, rm;
        cfg_write(0, 0, 558);
        cfg_write(0, 3, 3'b111);
        frame(1, -1, -1, 0, dc, nd, no, rm);
        model_step();
        vec++; if (o_x1[CW-1:0] !== CW'(559 - HS)) begin
            bad++; $display("FAIL x_bounce_hit got %0d want %0d", o_x1[CW-1:0], 559 - HS);
        end
        frame(1, -1, -1, 0, dc, nd, no, rm);
        model_step();
        vec++; if (o_x1[CW-1:0] !== CW'(558 - HS)) begin
            bad++; $display("FAIL x_bounce_back got %0d want %0d", o_x1[CW-1:0], 558 - HS);
        end
        vec++; if ({o_x1, o_x2, o_y1, o_y2} !== exp_boxes()) begin
            bad++; $display("FAIL x_bounce_boxes got %h want %h", {o_x1, o_x2, o_y1, o_y2}, exp_boxes());
        end
    endtask

    task automatic test_y_bounce();
        int dc, nd, no, rm;
        cfg_write(1, 1, 81);
        cfg_write(1, 3, 3'b101);
        frame(1, -1, -1, 0, dc, nd, no, rm);
        model_step();
        vec++; if (o_y1[CW +: CW] !== CW'(0)) begin
            bad++; $display("FAIL y_bounce_hit got %0d want 0", o_y1[CW +: CW]);
        end
        frame(1, -1, -1, 0, dc, nd, no, rm);
        model_step();
        vec++; if (o_y1[CW +: CW] !== CW'(1)) begin
            bad++; $display("FAIL y_bounce_back got %0d want 1", o_y1[CW +: CW]);
        end
        vec++; if ({o_x1, o_x2, o_y1, o_y2} !== exp_boxes()) begin
            bad++; $display("FAIL y_bounce_boxes got %h want %h", {o_x1, o_x2, o_y1, o_y2}, exp_boxes());
        end
    endtask

    task automatic test_cfg_arbitration();
        int dc, nd, no, rm;
        int sx, sy; bit sxd, syd;
        sx = mx[1]; sy = my[1]; sxd = mxd[1]; syd = myd[1];
        frame(1, -1, -1, 1, dc, nd, no, rm);
        model_step();
        mx[1] = 300; my[1] = sy; mxd[1] = sxd; myd[1] = syd;
        vec++; if (rm !== ((1 << 3) | (1 << 6) | (1 << 9))) begin
            bad++; $display("FAIL arb_ready_low got %h want %h", rm, (1 << 3) | (1 << 6) | (1 << 9));
        end
        vec++; if (dc !== 10) begin bad++; $display("FAIL arb_done_cycle got %0d want 10", dc); end
        vec++; if (o_x1[CW +: CW] !== CW'(300 - HS)) begin
            bad++; $display("FAIL arb_host_wins got %0d want %0d", o_x1[CW +: CW], 300 - HS);
        end
        vec++; if ({o_x1, o_x2, o_y1, o_y2} !== exp_boxes()) begin
            bad++; $display("FAIL arb_boxes got %h want %h", {o_x1, o_x2, o_y1, o_y2}, exp_boxes());
        end
    endtask

    task automatic test_overrun();
        int dc, nd, no, rm;
        frame(1, 5, -1, 0, dc, nd, no, rm);
        model_step();
        vec++; if (no !== 1) begin bad++; $display("FAIL overrun_count got %0d want 1", no); end
        vec++; if (nd !== 1 || dc !== 10) begin
            bad++; $display("FAIL overrun_done got %0d at %0d want 1 at 10", nd, dc);
        end
        vec++; if ({o_x1, o_x2, o_y1, o_y2} !== exp_boxes()) begin
            bad++; $display("FAIL overrun_boxes got %h want %h", {o_x1, o_x2, o_y1, o_y2}, exp_boxes());
        end
        frame(4, -1, -1, 0, dc, nd, no, rm);
        model_step();
        vec++; if (nd !== 1 || no !== 0 || dc !== 10) begin
            bad++; $display("FAIL held_animate got done %0d at %0d overrun %0d want 1 at 10, 0", nd, dc, no);
        end
        vec++; if ({o_x1, o_x2, o_y1, o_y2} !== exp_boxes()) begin
            bad++; $display("FAIL held_boxes got %h want %h", {o_x1, o_x2, o_y1, o_y2}, exp_boxes());
        end
    endtask

    task automatic test_disable();
        int dc, nd, no, rm;
        cfg_write(1, 3, 3'b011);
        frame(1, -1, -1, 0, dc, nd, no, rm);
        model_step();
        vec++; if (dc !== 8) begin bad++; $display("FAIL disable_done_cycle got %0d want 8", dc); end
        vec++; if ({o_x1, o_x2, o_y1, o_y2} !== exp_boxes()) begin
            bad++; $display("FAIL disable_boxes got %h want %h", {o_x1, o_x2, o_y1, o_y2}, exp_boxes());
        end
    endtask

    task automatic test_mid_reset();
        int dc, nd, no, rm;
        frame(1, -1, 4, 0, dc, nd, no, rm);
        model_reset();
        vec++; if (nd !== 0) begin bad++; $display("FAIL midreset_done got %0d want 0", nd); end
        vec++; if (o_busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got %b want 0", o_busy); end
        vec++; if ({o_x1, o_x2, o_y1, o_y2} !== exp_boxes()) begin
            bad++; $display("FAIL midreset_boxes got %h want %h", {o_x1, o_x2, o_y1, o_y2}, exp_boxes());
        end
    endtask

    task automatic test_random();
        int dc, nd, no, rm, hs, px, py, ed;
        for (int it = 0; it < 12; it++) begin
            for (int k = 0; k < N; k++) begin
                hs = $urandom_range(10, 60);
                case ($urandom_range(0, 4))
                    0: px = hs;
                    1: px = hs + 1;
                    2: px = W - 2 - hs;
                    3: px = W - 1 - hs;
                    default: px = $urandom_range(hs, W - 1 - hs);
                endcase
                py = ($urandom_range(0, 1) != 0) ? $urandom_range(hs, H - 1 - hs)
                                                 : (($urandom_range(0, 1) != 0) ? hs + 1 : H - 2 - hs);
                cfg_write(k, 2, hs);
                cfg_write(k, 0, px);
                cfg_write(k, 1, py);
                cfg_write(k, 3, {$urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))});
            end
            for (int f = 0; f < 2; f++) begin
                ed = exp_done();
                frame(1, -1, -1, 0, dc, nd, no, rm);
                model_step();
                vec++; if (dc !== ed || nd !== 1) begin
                    bad++; $display("FAIL rand_done it%0d got %0d x%0d want %0d x1", it, dc, nd, ed);
                end
                vec++; if ({o_x1, o_x2, o_y1, o_y2} !== exp_boxes()) begin
                    bad++; $display("FAIL rand_boxes it%0d got %h want %h", it, {o_x1, o_x2, o_y1, o_y2}, exp_boxes());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_host_write();
        test_x_bounce();
        test_y_bounce();
        test_cfg_arbitration();
        test_overrun();
        test_disable();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
